pi_output_stream_buffer: RTL and testbench



---
 rtl/pi_stream_pkg.sv | 16 +
 rtl/sync_fifo_showahead.sv | 75 +++++++
 rtl/pi_output_stream_buffer.sv | 122 ++++++++++++
 tb/tb_pi_output_stream_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_stream_pkg.sv
// rtl/pi_stream_pkg.sv - word format and shared constants for the PI output stream buffer
package pi_stream_pkg;

  localparam int WORD_WIDTH     = 16;
  localparam int FIRST_BIT      = 15;
  localparam int GAP_BIT        = 14;
  localparam int SAMPLE_MSB     = 13;
  localparam int SAMPLE_FIELD_W = SAMPLE_MSB + 1;

  localparam logic [15:0] OVF_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == OVF_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_showahead.sv
// rtl/sync_fifo_showahead.sv - single-clock show-ahead FIFO with registered head word and synchronous clear
module sync_fifo_showahead #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  full,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_b, rd_ptr_b;
  logic [DEPTH_LOG2:0]   count_q, count_b, count_d, mem_words;
  logic                  head_vld_q, head_vld_b;
  logic [WIDTH-1:0]      head_q;
  logic                  do_wr, do_pop, do_load;

  assign full  = (count_q == DEPTH_CNT);
  assign rdata = head_q;
  assign empty = ~head_vld_q;
  assign count = count_q;

  // count includes the head register; a word only reaches the head one edge after it lands in memory
  always_comb begin
    wr_ptr_b   = clear ? '0 : wr_ptr_q;
    rd_ptr_b   = clear ? '0 : rd_ptr_q;
    count_b    = clear ? '0 : count_q;
    head_vld_b = clear ? 1'b0 : head_vld_q;
    do_pop     = rd & head_vld_q & ~clear;
    do_wr      = wr & (clear | ~full);
    mem_words  = count_b - {{DEPTH_LOG2{1'b0}}, head_vld_b};
    do_load    = (mem_words != '0) && (~head_vld_b || do_pop);
    count_d    = count_b + {{DEPTH_LOG2{1'b0}}, do_wr} - {{DEPTH_LOG2{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_b] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q <= do_wr ? wr_ptr_b + 1'b1 : wr_ptr_b;
      rd_ptr_q <= do_load ? rd_ptr_b + 1'b1 : rd_ptr_b;
      count_q  <= count_d;
      if (do_load) begin
        head_vld_q <= 1'b1;
        head_q     <= mem_q[rd_ptr_b];
      end else begin
        head_vld_q <= head_vld_b & ~do_pop;
        if (clear) begin
          head_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pi_output_stream_buffer.sv
// rtl/pi_output_stream_buffer.sv - decimate, tag and buffer PI output samples for the UDP streamer; PI_STREAM_TESTPAT_EN adds a counter test pattern
module pi_output_stream_buffer
  import pi_stream_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 14,
  parameter int DEPTH_LOG2   = 10,
  parameter int DECIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DECIM_WIDTH-1:0]  decimation,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
`ifdef PI_STREAM_TESTPAT_EN
  input  logic                    test_mode,
`endif
  input  logic                    rdreq,
  output logic [15:0]             rddata,
  output logic                    rdempty,
  output logic [DEPTH_LOG2:0]     fill_level,
  output logic [15:0]             overflow_count
);

  logic                      enable_q;
  logic [DECIM_WIDTH-1:0]    dec_cnt_q, dec_cnt_d, dec_cnt_b;
  logic [DECIM_WIDTH-1:0]    dec_ratio_q, dec_ratio_d, dec_ratio_b;
  logic                      first_q, first_d, first_b;
  logic                      gap_q, gap_d, gap_b;
  logic [15:0]               ovf_q, ovf_d, ovf_b;
  logic                      enable_rise, advance, selected, accept, drop, wrap;
  logic                      fifo_full;
  logic [SAMPLE_FIELD_W-1:0] sample_ext, field;
  logic [WORD_WIDTH-1:0]     wdata;

  assign enable_rise = enable & ~enable_q;
  assign sample_ext  = SAMPLE_FIELD_W'($signed(sample_in));

`ifdef PI_STREAM_TESTPAT_EN
  logic [SAMPLE_FIELD_W-1:0] tp_q, tp_d, tp_b;

  // pattern advances on every selected sample, dropped or not, so gaps show up as jumps
  always_comb begin
    tp_b  = enable_rise ? '0 : tp_q;
    tp_d  = selected ? tp_b + 1'b1 : tp_b;
    field = test_mode ? tp_b : sample_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q <= '0;
    end else begin
      tp_q <= tp_d;
    end
  end
`else
  assign field = sample_ext;
`endif

  // _b values are the state as seen this cycle, with an enable rise applying the flush first
  always_comb begin
    dec_cnt_b   = enable_rise ? '0 : dec_cnt_q;
    dec_ratio_b = enable_rise ? decimation : dec_ratio_q;
    first_b     = enable_rise | first_q;
    gap_b       = ~enable_rise & gap_q;
    ovf_b       = enable_rise ? 16'd0 : ovf_q;

    advance  = enable & sample_valid;
    selected = advance & (dec_cnt_b == '0);
    accept   = selected & (enable_rise | ~fifo_full);
    drop     = selected & ~accept;
    wrap     = advance & (dec_cnt_b == dec_ratio_b);

    dec_cnt_d   = advance ? (wrap ? '0 : dec_cnt_b + 1'b1) : dec_cnt_b;
    dec_ratio_d = wrap ? decimation : dec_ratio_b;
    first_d     = accept ? 1'b0 : first_b;
    gap_d       = accept ? 1'b0 : (drop | gap_b);
    ovf_d       = drop ? sat_inc16(ovf_b) : ovf_b;

    wdata                   = '0;
    wdata[FIRST_BIT]        = first_b;
    wdata[GAP_BIT]          = gap_b;
    wdata[SAMPLE_MSB:0]     = field;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= 1'b0;
      dec_cnt_q   <= '0;
      dec_ratio_q <= '0;
      first_q     <= 1'b1;
      gap_q       <= 1'b0;
      ovf_q       <= 16'd0;
    end else begin
      enable_q    <= enable;
      dec_cnt_q   <= dec_cnt_d;
      dec_ratio_q <= dec_ratio_d;
      first_q     <= first_d;
      gap_q       <= gap_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo_showahead #(
    .WIDTH      (WORD_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clear (enable_rise),
    .wr    (accept),
    .wdata (wdata),
    .full  (fifo_full),
    .rd    (rdreq),
    .rdata (rddata),
    .empty (rdempty),
    .count (fill_level)
  );

  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_pi_output_stream_buffer.sv
// tb/tb_pi_output_stream_buffer.sv - scoreboard bench with a queue-level reference model of the stream buffer
module tb_pi_output_stream_buffer;

  localparam int SW    = 12;
  localparam int DL2   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          reset, enable, sample_valid, rdreq;
  logic [DW-1:0] decimation;
  logic [SW-1:0] sample_in;
`ifdef PI_STREAM_TESTPAT_EN
  logic          test_mode = 1'b0;
`endif
  logic [15:0]   rddata;
  logic          rdempty;
  logic [DL2:0]  fill_level;
  logic [15:0]   overflow_count;

  pi_output_stream_buffer #(
    .SAMPLE_WIDTH (SW),
    .DEPTH_LOG2   (DL2),
    .DECIM_WIDTH  (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .decimation     (decimation),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
`ifdef PI_STREAM_TESTPAT_EN
    .test_mode      (test_mode),
`endif
    .rdreq          (rdreq),
    .rddata         (rddata),
    .rdempty        (rdempty),
    .fill_level     (fill_level),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int          e;
  } ent_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_edge = 0;
  bit          m_en_prev, m_first, m_gap, mon_en = 1'b0, mon_vis;
  int          m_pos, m_ratio, m_ovf, m_tp;
  ent_t        m_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] sext(input logic [SW-1:0] s);
    logic [13:0] r;
    r = 14'(s);
    if (s[SW-1]) r = r - 14'(1 << SW);
    return r;
  endfunction

  task automatic model_reset();
    m_en_prev = 1'b0;
    m_pos     = 0;
    m_ratio   = 0;
    m_first   = 1'b1;
    m_gap     = 1'b0;
    m_ovf     = 0;
    m_tp      = 0;
    m_q.delete();
    exp_q.delete();
  endtask

  // A word written at edge E is visible at the head from edge E+1 onward.
  task automatic model_edge();
    bit          rise, full, vis, sel;
    logic [13:0] field;
    logic [15:0] w;
    ent_t        ent;
    m_edge++;
    if (reset) begin
      model_reset();
      return;
    end
    rise      = enable && !m_en_prev;
    m_en_prev = enable;
    vis       = (m_q.size() > 0) && (m_q[0].e < m_edge - 1);
    full      = (m_q.size() == DEPTH);
    if (rise) begin
      m_q.delete();
      exp_q.delete();
      vis = 1'b0; full = 1'b0;
      m_ovf = 0; m_pos = 0; m_ratio = int'(decimation);
      m_first = 1'b1; m_gap = 1'b0; m_tp = 0;
    end
    if (rdreq && vis) m_q.delete(0);
    if (enable && sample_valid) begin
      sel = (m_pos == 0);
      if (m_pos == m_ratio) begin
        m_pos = 0;
        m_ratio = int'(decimation);
      end else begin
        m_pos++;
      end
      if (sel) begin
`ifdef PI_STREAM_TESTPAT_EN
        field = test_mode ? 14'(m_tp) : sext(sample_in);
`else
        field = sext(sample_in);
`endif
        if (full) begin
          m_gap = 1'b1;
          if (m_ovf < 65535) m_ovf++;
        end else begin
          w = {m_first, m_gap, field};
          ent.w = w;
          ent.e = m_edge;
          m_q.push_back(ent);
          exp_q.push_back(w);
          m_first = 1'b0;
          m_gap = 1'b0;
        end
        m_tp = (m_tp + 1) % 16384;
      end
    end
  endtask

  task automatic drive(input bit en, input bit sv, input bit rq, input logic [SW-1:0] s, input logic [DW-1:0] dec);
    enable       = en;
    sample_valid = sv;
    rdreq        = rq;
    sample_in    = s;
    decimation   = dec;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_vis = (m_q.size() > 0) && (m_q[0].e < m_edge);
      check("rdempty", 32'(rdempty), 32'(!mon_vis));
      check("fill_level", 32'(fill_level), 32'(m_q.size()));
      check("overflow_count", 32'(overflow_count), 32'(m_ovf));
      if (rdreq && !rdempty) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no word", rddata);
        end else begin
          check("rddata", 32'(rddata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int          bias, en_off;
    logic [DW-1:0] dec;
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; rdreq = 1'b0;
    sample_in = '0; decimation = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rddata", 32'(rddata), 32'h0);
    check("reset_rdempty", 32'(rdempty), 32'h1);
    check("reset_fill", 32'(fill_level), 32'h0);
    check("reset_ovf", 32'(overflow_count), 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // five strobes, every sample kept
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, SW'(i), '0);
      if (i == 1) check("lat_empty_after_1", 32'(rdempty), 32'h1);
      if (i == 2) begin
        check("lat_empty_after_2", 32'(rdempty), 32'h0);
        check("first_word", 32'(rddata), 32'h8001);
      end
    end
    check("p1_fill", 32'(fill_level), 32'd5);
    repeat (8) drive(1, 0, 1, '0, '0);

    // decimation 3 over 12 strobes
    drive(0, 0, 0, '0, 16'd3);
    for (int i = 0; i < 12; i++) drive(1, 1, 0, SW'(i), 16'd3);
    repeat (2) drive(1, 0, 0, '0, 16'd3);
    check("p2_fill", 32'(fill_level), 32'd3);
    repeat (5) drive(1, 0, 1, '0, 16'd3);

    // overflow: 20 strobes into 16 slots
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, SW'($urandom), '0);
    repeat (2) drive(1, 0, 0, '0, '0);
    check("p3_fill_full", 32'(fill_level), 32'd16);
    check("p3_ovf", 32'(overflow_count), 32'd4);
    drive(1, 1, 1, SW'(9), '0);
    check("p3_drop_fill", 32'(fill_level), 32'd15);
    check("p3_drop_ovf", 32'(overflow_count), 32'd5);
    drive(1, 1, 0, SW'(7), '0);
    repeat (20) drive(1, 0, 1, '0, '0);

    // asynchronous reset with 7 words stored
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 7; i++) drive(1, 1, 0, SW'($urandom), '0);
    repeat (2) drive(1, 0, 0, '0, '0);
    check("p4_fill_before", 32'(fill_level), 32'd7);
    #3 reset = 1'b1;
    model_reset();
    #1;
    check("async_rdempty", 32'(rdempty), 32'h1);
    check("async_fill", 32'(fill_level), 32'h0);
    check("async_ovf", 32'(overflow_count), 32'h0);
    @(posedge clk);
    model_edge();
    #1 reset = 1'b0;
    drive(1, 1, 0, SW'(3), '0);
    drive(1, 0, 0, '0, '0);
    check("post_reset_first_bit", 32'(rddata[15]), 32'h1);
    repeat (4) drive(1, 0, 1, '0, '0);

`ifdef PI_STREAM_TESTPAT_EN
    test_mode = 1'b1;
    drive(0, 0, 0, '0, 16'd1);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, SW'($urandom), 16'd1);
    drive(1, 0, 0, '0, 16'd1);
    check("tp_first_word", 32'(rddata), 32'h8000);
    repeat (6) drive(1, 0, 1, '0, 16'd1);
    test_mode = 1'b0;
`endif

    // randomized traffic
    bias = 50; en_off = 0; dec = '0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) bias = $urandom_range(10, 90);
      if (c % 100 == 0) dec = DW'($urandom_range(0, 4));
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 5);
`ifdef PI_STREAM_TESTPAT_EN
      if (c % 700 == 0) test_mode = 1'($urandom_range(0, 1));
`endif
      drive(en_off == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < bias, SW'($urandom), dec);
    end
    repeat (40) drive(1, 0, 1, '0, dec);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
